// File: rtl/pause_fade.sv
// Pause controller for arcade cores: it merges the pause sources, supports single-frame
// stepping while user-paused, and fades the video to a brightness floor after a pause timeout.
module pause_fade #(
   parameter int RW          = 8,
   parameter int GW          = 8,
   parameter int BW          = 8,
   parameter int NREQ        = 2,
   parameter int CLKSPD      = 12,
   parameter int SEC_CYCLES  = CLKSPD * 1000000,
   parameter int DIM_SECS    = 10,
   parameter int DIM_LEVEL   = 8,
   parameter int FADE_FRAMES = 4
) (
   input  logic                  clk_sys,
   input  logic                  reset,
   input  logic                  user_button,
   input  logic                  step_button,
   input  logic [NREQ-1:0]       pause_request,
   input  logic [NREQ-1:0]       req_mask,
   input  logic [1:0]            options,
   input  logic                  OSD_STATUS,
   input  logic                  vblank,
   input  logic [RW-1:0]         r,
   input  logic [GW-1:0]         g,
   input  logic [BW-1:0]         b,
   output logic                  pause_cpu,
   output logic                  user_paused,
   output logic                  dim_active,
   output logic [4:0]            bright,
   output logic [RW+GW+BW-1:0]   rgb_out
);

   // state | meaning
   // IDLE  | no step pending
   // ARM   | step accepted, waiting for the next vblank to release the CPU
   // RUN   | CPU released for one frame, re-paused at the next vblank
   typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN} step_t;

   localparam int PW = $clog2(SEC_CYCLES + 1);
   localparam int FW = $clog2(FADE_FRAMES + 1);

   step_t           state;
   logic            toggle;
   logic            btn_q, btn_armed, step_q, vb_q;
   logic [PW-1:0]   prescaler;
   logic [7:0]      sec_cnt;
   logic [FW-1:0]   frame_cnt;
   logic [4:0]      bright_q;
   logic            dim_q;
   logic [RW+GW+BW-1:0] rgb_q;

   logic req_hit, osd_hold, stepping, step_ok;
   logic user_edge, step_edge, vb_edge, dim_run;

   assign req_hit   = |(pause_request & req_mask);
   assign osd_hold  = OSD_STATUS & options[0];
   assign stepping  = (state == S_RUN);
   assign step_ok   = toggle & ~req_hit & ~osd_hold;
   assign user_edge = user_button & ~btn_q & btn_armed;
   assign step_edge = step_button & ~step_q;
   assign vb_edge   = vblank & ~vb_q;
   assign pause_cpu = (req_hit | (toggle & ~stepping) | osd_hold) & ~reset;
   assign dim_run   = pause_cpu & options[1];

   assign user_paused = toggle;
   assign dim_active  = dim_q;
   assign bright      = bright_q;
   assign rgb_out     = rgb_q;

   // btn_armed blocks a button that is already held when reset releases
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         btn_q     <= 1'b0;
         btn_armed <= 1'b0;
         step_q    <= 1'b0;
         vb_q      <= 1'b0;
         toggle    <= 1'b0;
      end else begin
         btn_q  <= user_button;
         step_q <= step_button;
         vb_q   <= vblank;
         if (!user_button)
            btn_armed <= 1'b1;
         if (user_edge)
            toggle <= ~toggle;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (step_edge && step_ok && !user_edge) state <= S_ARM;
            S_ARM:   if (user_edge || !step_ok) state <= S_IDLE;
                     else if (vb_edge)          state <= S_RUN;
            S_RUN:   if (user_edge || !step_ok || vb_edge) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         prescaler <= '0;
         sec_cnt   <= 8'd0;
         dim_q     <= 1'b0;
      end else if (dim_run) begin
         dim_q <= (sec_cnt == 8'(DIM_SECS));
         if (prescaler == PW'(SEC_CYCLES - 1)) begin
            prescaler <= '0;
            if (sec_cnt != 8'(DIM_SECS))
               sec_cnt <= sec_cnt + 8'd1;
         end else begin
            prescaler <= prescaler + PW'(1);
         end
      end else begin
         prescaler <= '0;
         sec_cnt   <= 8'd0;
         dim_q     <= 1'b0;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         frame_cnt <= '0;
         bright_q  <= 5'd16;
      end else if (!dim_q) begin
         frame_cnt <= '0;
         bright_q  <= 5'd16;
      end else if (vb_edge) begin
         if (frame_cnt == FW'(FADE_FRAMES - 1)) begin
            frame_cnt <= '0;
            if (bright_q > 5'(DIM_LEVEL))
               bright_q <= bright_q - 5'd1;
         end else begin
            frame_cnt <= frame_cnt + FW'(1);
         end
      end
   end

   logic [RW+4:0] r_prod;
   logic [GW+4:0] g_prod;
   logic [BW+4:0] b_prod;
   assign r_prod = {5'b0, r} * {{RW{1'b0}}, bright_q};
   assign g_prod = {5'b0, g} * {{GW{1'b0}}, bright_q};
   assign b_prod = {5'b0, b} * {{BW{1'b0}}, bright_q};

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)
         rgb_q <= '0;
      else
         rgb_q <= {RW'(r_prod >> 4), GW'(g_prod >> 4), BW'(b_prod >> 4)};
   end

endmodule
